// File: rtl/sim_model_clock_gen.sv
// rtl/sim_model_clock_gen.sv - model-clock generator with stop, free-run, single-step and burst modes
module sim_model_clock_gen #(
  parameter int DIV_WIDTH   = 24,
  parameter int BURST_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [1:0]             mode,
  input  logic [DIV_WIDTH-1:0]   half_period,
  input  logic                   step,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   model_clk,
  output logic                   rise,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   period_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP
  } state_t;

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic                   clk_q, clk_d;
  logic                   rise_q, rise_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   toggle;

  // >= rather than == so that lowering half_period mid-phase toggles at once
  assign toggle = (div_cnt_q >= half_period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      rem_q     <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      rem_q     <= rem_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    rem_d     = rem_q;
    clk_d     = clk_q;
    rise_d    = 1'b0;
    cnt_d     = cnt_q;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          div_cnt_d = '0;
          clk_d     = 1'b0;
          if (mode == MODE_RUN) begin
            state_d = S_RUN;
          end else if (mode == MODE_STEP && step) begin
            state_d = S_STEP;
            rem_d   = BURST_WIDTH'(1);
          end else if (mode == MODE_BURST && step && burst_len != '0) begin
            state_d = S_STEP;
            rem_d   = burst_len;
          end
        end
        S_RUN: begin
          // a high phase always runs to its falling toggle before stopping
          if (mode != MODE_RUN && !clk_q) begin
            state_d   = S_IDLE;
            div_cnt_d = '0;
          end else if (toggle) begin
            div_cnt_d = '0;
            clk_d     = ~clk_q;
            if (!clk_q) begin
              rise_d = 1'b1;
              cnt_d  = cnt_q + CNT_WIDTH'(1);
            end else if (mode != MODE_RUN) begin
              state_d = S_IDLE;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
          end
        end
        S_STEP: begin
          if (toggle) begin
            div_cnt_d = '0;
            clk_d     = ~clk_q;
            if (!clk_q) begin
              rise_d = 1'b1;
              cnt_d  = cnt_q + CNT_WIDTH'(1);
            end else begin
              rem_d = rem_q - BURST_WIDTH'(1);
              if (rem_q == BURST_WIDTH'(1)) state_d = S_IDLE;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
          end
        end
        default: begin
          state_d   = S_IDLE;
          div_cnt_d = '0;
          clk_d     = 1'b0;
        end
      endcase
    end
  end

  assign model_clk    = clk_q;
  assign rise         = rise_q;
  assign busy         = (state_q != S_IDLE);
  assign period_count = cnt_q;

endmodule
